// File: rtl/pc_gen.sv
// Fetch address generator: BOOT/RUN/HALT control, redirects, trap entry/return.
// Optional target alignment check enabled by defining PC_MISALIGN_CHK_EN.
module pc_gen #(
   parameter int              XLEN      = 32,
   parameter int              STEP      = 1,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_ready,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            trap_req,
   input  logic            trap_ret,
   input  logic            halt_req,
   input  logic            resume_req,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus_step,
   output logic            fetch_valid,
   output logic [XLEN-1:0] epc,
   output logic            redirected,
   output logic            halted,
   output logic            misalign
);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

   localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

   state_t          state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] epc_reg, epc_next;
   logic            redirected_reg, redirected_next;
   logic [XLEN-1:0] jump_target;
   logic            jump_bad;

   // trap_ret outranks br_taken, so its source wins the shared target mux
   assign jump_target = trap_ret ? epc_reg : br_target;

`ifdef PC_MISALIGN_CHK_EN
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
   logic misalign_reg, misalign_next;
   assign jump_bad = (jump_target & ALIGN_MASK) != '0;
`else
   assign jump_bad = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      epc_next        = epc_reg;
      redirected_next = redirected_reg;
`ifdef PC_MISALIGN_CHK_EN
      misalign_next   = 1'b0;
`endif
      case (state_reg)
         ST_BOOT: state_next = ST_RUN;
         ST_RUN: begin
            if (trap_req) begin
               pc_next         = TRAP_VEC;
               epc_next        = pc_reg;
               redirected_next = 1'b1;
            end else if (trap_ret || br_taken) begin
               redirected_next = 1'b1;
               if (jump_bad) begin
                  // misaligned target turns into a trap reporting the bad address
                  pc_next  = TRAP_VEC;
                  epc_next = jump_target;
`ifdef PC_MISALIGN_CHK_EN
                  misalign_next = 1'b1;
`endif
               end else begin
                  pc_next = jump_target;
               end
            end else if (halt_req) begin
               state_next = ST_HALT;
            end else if (fetch_ready) begin
               pc_next         = pc_plus_step;
               redirected_next = 1'b0;
            end
         end
         ST_HALT: begin
            if (trap_req) begin
               pc_next         = TRAP_VEC;
               epc_next        = pc_reg;
               redirected_next = 1'b1;
               state_next      = ST_RUN;
            end else if (resume_req) begin
               state_next = ST_RUN;
            end
         end
         default: state_next = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_BOOT;
         pc_reg         <= RESET_VEC;
         epc_reg        <= '0;
         redirected_reg <= 1'b0;
`ifdef PC_MISALIGN_CHK_EN
         misalign_reg   <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         epc_reg        <= epc_next;
         redirected_reg <= redirected_next;
`ifdef PC_MISALIGN_CHK_EN
         misalign_reg   <= misalign_next;
`endif
      end
   end

   assign pc           = pc_reg;
   assign pc_plus_step = pc_reg + STEP_V;
   assign epc          = epc_reg;
   assign redirected   = redirected_reg;
   assign fetch_valid  = (state_reg == ST_RUN);
   assign halted       = (state_reg == ST_HALT);
`ifdef PC_MISALIGN_CHK_EN
   assign misalign     = misalign_reg;
`else
   assign misalign     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a STEP=1 instance driven through a scoreboard of
// per-cycle expectations, plus a STEP=4 instance for the alignment check.
module tb_pc_gen;

   typedef struct {
      logic [31:0] pc;
      logic        fv;
      logic        red;
      logic        hlt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_ready = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic        trap_req = 1'b0;
   logic        trap_ret = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume_req = 1'b0;
   logic [31:0] pc, pc_plus_step, epc;
   logic        fetch_valid, redirected, halted, misalign;

   logic        b_ready = 1'b0;
   logic        b_br = 1'b0;
   logic [31:0] b_tgt = '0;
   logic [31:0] b_pc, b_pps, b_epc;
   logic        b_fv, b_red, b_hlt, b_mis;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .STEP(1)) u_dut (
      .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .br_taken(br_taken),
      .br_target(br_target), .trap_req(trap_req), .trap_ret(trap_ret),
      .halt_req(halt_req), .resume_req(resume_req), .pc(pc),
      .pc_plus_step(pc_plus_step), .fetch_valid(fetch_valid), .epc(epc),
      .redirected(redirected), .halted(halted), .misalign(misalign)
   );

   pc_gen #(.XLEN(32), .STEP(4)) u_dut4 (
      .clk(clk), .rst(rst), .fetch_ready(b_ready), .br_taken(b_br),
      .br_target(b_tgt), .trap_req(1'b0), .trap_ret(1'b0),
      .halt_req(1'b0), .resume_req(1'b0), .pc(b_pc),
      .pc_plus_step(b_pps), .fetch_valid(b_fv), .epc(b_epc),
      .redirected(b_red), .halted(b_hlt), .misalign(b_mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // push the expected post-edge state, advance one edge, pop and compare
   task automatic cyc(input logic [31:0] epc_v, input logic fv, input logic red, input logic hlt);
      exp_t e;
      e.pc = epc_v; e.fv = fv; e.red = red; e.hlt = hlt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus_step", pc_plus_step, e.pc + 32'd1);
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      chk("redirected", {31'd0, redirected}, {31'd0, e.red});
      chk("halted", {31'd0, halted}, {31'd0, e.hlt});
      chk("misalign_step1", {31'd0, misalign}, 32'd0);
      $display("cycle t=%0t pc=%h fv=%b red=%b hlt=%b epc=%h", $time, pc, fetch_valid, redirected, halted, epc);
   endtask

   initial begin
      // reset for two edges
      cyc(32'h0, 1'b0, 1'b0, 1'b0);
      cyc(32'h0, 1'b0, 1'b0, 1'b0);
      chk("epc_reset", epc, 32'h0);
      rst = 1'b0; fetch_ready = 1'b1;
      cyc(32'h0, 1'b1, 1'b0, 1'b0);      // BOOT -> RUN, first valid fetch
      for (int i = 1; i <= 5; i++) cyc(32'(i), 1'b1, 1'b0, 1'b0);
      // stall at pc=5
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc(32'h5, 1'b1, 1'b0, 1'b0);
      fetch_ready = 1'b1;
      cyc(32'h6, 1'b1, 1'b0, 1'b0);
      cyc(32'h7, 1'b1, 1'b0, 1'b0);
      cyc(32'h8, 1'b1, 1'b0, 1'b0);
      // branch while stalled
      fetch_ready = 1'b0; br_taken = 1'b1; br_target = 32'h40;
      cyc(32'h40, 1'b1, 1'b1, 1'b0);
      br_taken = 1'b0; fetch_ready = 1'b1;
      cyc(32'h41, 1'b1, 1'b0, 1'b0);
      br_taken = 1'b1; br_target = 32'h20;
      cyc(32'h20, 1'b1, 1'b1, 1'b0);
      // trap beats branch
      trap_req = 1'b1; br_target = 32'h55;
      cyc(32'h100, 1'b1, 1'b1, 1'b0);
      chk("epc_trap", epc, 32'h20);
      trap_req = 1'b0; br_taken = 1'b0;
      cyc(32'h101, 1'b1, 1'b0, 1'b0);
      trap_ret = 1'b1;
      cyc(32'h20, 1'b1, 1'b1, 1'b0);
      trap_ret = 1'b0; br_taken = 1'b1; br_target = 32'h10;
      cyc(32'h10, 1'b1, 1'b1, 1'b0);
      // halt at 0x10; redirect/trap_ret inputs ignored while halted
      br_taken = 1'b0; halt_req = 1'b1;
      cyc(32'h10, 1'b0, 1'b1, 1'b1);
      halt_req = 1'b0; br_taken = 1'b1; br_target = 32'h77; trap_ret = 1'b1;
      for (int i = 0; i < 5; i++) cyc(32'h10, 1'b0, 1'b1, 1'b1);
      br_taken = 1'b0; trap_ret = 1'b0; resume_req = 1'b1;
      cyc(32'h10, 1'b1, 1'b1, 1'b0);
      resume_req = 1'b0;
      cyc(32'h11, 1'b1, 1'b0, 1'b0);
      // halt again, then trap in HALT wins over resume
      halt_req = 1'b1;
      cyc(32'h11, 1'b0, 1'b0, 1'b1);
      halt_req = 1'b0; trap_req = 1'b1; resume_req = 1'b1;
      cyc(32'h100, 1'b1, 1'b1, 1'b0);
      chk("epc_halt_trap", epc, 32'h11);
      trap_req = 1'b0; resume_req = 1'b0;
      // halt_req with a branch: branch applied, halt deferred
      halt_req = 1'b1; br_taken = 1'b1; br_target = 32'h30;
      cyc(32'h30, 1'b1, 1'b1, 1'b0);
      br_taken = 1'b0;
      cyc(32'h30, 1'b0, 1'b1, 1'b1);
      halt_req = 1'b0;
      cyc(32'h30, 1'b0, 1'b1, 1'b1);
      // reset while halted
      rst = 1'b1;
      cyc(32'h0, 1'b0, 1'b0, 1'b0);
      chk("epc_rst_halt", epc, 32'h0);
      rst = 1'b0;
      cyc(32'h0, 1'b1, 1'b0, 1'b0);
      // wrap at the top of the address space
      br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
      cyc(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
      br_taken = 1'b0;
      cyc(32'h0, 1'b1, 1'b0, 1'b0);
      fetch_ready = 1'b0;

      // STEP=4 instance: it has been stalled at pc=0 in RUN since reset
      chk("b_pc_idle", b_pc, 32'h0);
      chk("b_pps", b_pps, 32'h4);
      b_br = 1'b1; b_tgt = 32'h42;
      @(posedge clk); #1;
`ifdef PC_MISALIGN_CHK_EN
      chk("b_pc_mis", b_pc, 32'h100);
      chk("b_epc_mis", b_epc, 32'h42);
      chk("b_misalign_set", {31'd0, b_mis}, 32'd1);
`else
      chk("b_pc_mis", b_pc, 32'h42);
      chk("b_misalign_set", {31'd0, b_mis}, 32'd0);
`endif
      chk("b_red", {31'd0, b_red}, 32'd1);
      $display("step4 t=%0t pc=%h epc=%h mis=%b", $time, b_pc, b_epc, b_mis);
      b_br = 1'b0;
      @(posedge clk); #1;
      chk("b_misalign_clr", {31'd0, b_mis}, 32'd0);
      b_br = 1'b1; b_tgt = 32'h44;
      @(posedge clk); #1;
      chk("b_pc_aligned", b_pc, 32'h44);
      b_br = 1'b0; b_ready = 1'b1;
      @(posedge clk); #1;
      chk("b_pc_step", b_pc, 32'h48);
      chk("b_pps_step", b_pps, 32'h4C);
      chk("b_red_clr", {31'd0, b_red}, 32'd0);
      $display("step4 t=%0t pc=%h pps=%h", $time, b_pc, b_pps);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
